// File: rtl/ddr3_gearbox_pkg.sv
// Shared definitions for the DDR3 pixel gearbox (packer and unpacker halves).
// Holds the default pixel/memory widths, a constant clog2 and the mapping
// from a slot index to its bit offset inside a memory word.
package ddr3_gearbox_pkg;

  localparam int unsigned DefPixW = 16;
  localparam int unsigned DefMemW = 256;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  // Bit offset of the LSB of slot 'slot'; slot 0 is the first pixel in time.
  function automatic int unsigned slot_offset(input int unsigned slot, input int unsigned ratio,
                                              input int unsigned pix_w, input bit msb_first);
    return msb_first ? (ratio - 1 - slot) * pix_w : slot * pix_w;
  endfunction

endpackage

// File: rtl/ddr3_pix_gearbox_if.sv
// Bundle of all gearbox handshake/data signals.
//   slave  : the gearbox side (consumes pixels and memory words, produces both)
//   master : the environment side driving the gearbox
interface ddr3_pix_gearbox_if
  import ddr3_gearbox_pkg::*;
#(
  parameter int unsigned PIX_W = DefPixW,
  parameter int unsigned MEM_W = DefMemW
) ();

  localparam int unsigned CW = clog2(MEM_W / PIX_W) + 1;

  // Packer side
  logic             pix_in_valid;
  logic             pix_in_ready;
  logic [PIX_W-1:0] pix_in_data;
  logic             pix_in_last;
  logic             wr_load;
  logic             mem_out_valid;
  logic             mem_out_ready;
  logic [MEM_W-1:0] mem_out_data;
  logic [CW-1:0]    mem_out_cnt;

  // Unpacker side
  logic             mem_in_valid;
  logic             mem_in_ready;
  logic [MEM_W-1:0] mem_in_data;
  logic [CW-1:0]    mem_in_cnt;
  logic             rd_load;
  logic             pix_out_valid;
  logic             pix_out_ready;
  logic [PIX_W-1:0] pix_out_data;
  logic             pix_out_last;

  modport slave (
    input  pix_in_valid, pix_in_data, pix_in_last, wr_load, mem_out_ready,
    input  mem_in_valid, mem_in_data, mem_in_cnt, rd_load, pix_out_ready,
    output pix_in_ready, mem_out_valid, mem_out_data, mem_out_cnt,
    output mem_in_ready, pix_out_valid, pix_out_data, pix_out_last
  );

  modport master (
    output pix_in_valid, pix_in_data, pix_in_last, wr_load, mem_out_ready,
    output mem_in_valid, mem_in_data, mem_in_cnt, rd_load, pix_out_ready,
    input  pix_in_ready, mem_out_valid, mem_out_data, mem_out_cnt,
    input  mem_in_ready, pix_out_valid, pix_out_data, pix_out_last
  );

endinterface

// File: rtl/ddr3_pix_unpack.sv
// Unpacker: holds one memory word and streams its pixels out in slot order.
//   clk_i, rst_ni               : clock, async active-low reset
//   mem_in_*                    : word to unpack plus pixel count (0 or >RATIO = full)
//   rd_load_i                   : frame start, drops the buffered word
//   pix_out_*                   : pixel stream, last flags the word's final pixel
module ddr3_pix_unpack
  import ddr3_gearbox_pkg::*;
#(
  parameter int unsigned PIX_W     = DefPixW,
  parameter int unsigned MEM_W     = DefMemW,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned RATIO    = MEM_W / PIX_W,
  localparam int unsigned CW       = clog2(RATIO) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mem_in_valid_i,
  output logic             mem_in_ready_o,
  input  logic [MEM_W-1:0] mem_in_data_i,
  input  logic [CW-1:0]    mem_in_cnt_i,
  input  logic             rd_load_i,
  output logic             pix_out_valid_o,
  input  logic             pix_out_ready_i,
  output logic [PIX_W-1:0] pix_out_data_o,
  output logic             pix_out_last_o
);

  logic [MEM_W-1:0] word_q, word_d;
  logic             buf_valid_q, buf_valid_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    lim_q, lim_d;
  logic [CW-1:0]    lim_in;
  logic             at_last;
  logic             word_acc;

  assign at_last  = (idx_q == lim_q - 1'b1);
  // A new word may enter while the final pixel of the current one leaves.
  assign mem_in_ready_o = ~rd_load_i & (~buf_valid_q | (pix_out_ready_i & at_last));
  assign word_acc = mem_in_valid_i & mem_in_ready_o;
  assign lim_in   = ((mem_in_cnt_i == '0) || (mem_in_cnt_i > CW'(RATIO))) ? CW'(RATIO)
                                                                           : mem_in_cnt_i;

  assign pix_out_valid_o = buf_valid_q;
  assign pix_out_last_o  = buf_valid_q & at_last;
  assign pix_out_data_o  = PIX_W'(word_q >> slot_offset(32'(idx_q), RATIO, PIX_W, MSB_FIRST));

  always_comb begin
    word_d      = word_q;
    buf_valid_d = buf_valid_q;
    idx_d       = idx_q;
    lim_d       = lim_q;
    if (rd_load_i) begin
      buf_valid_d = 1'b0;
      idx_d       = '0;
    end else if (word_acc) begin
      word_d      = mem_in_data_i;
      lim_d       = lim_in;
      idx_d       = '0;
      buf_valid_d = 1'b1;
    end else if (buf_valid_q && pix_out_ready_i) begin
      if (at_last) begin
        buf_valid_d = 1'b0;
        idx_d       = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q      <= '0;
      buf_valid_q <= 1'b0;
      idx_q       <= '0;
      lim_q       <= '0;
    end else begin
      word_q      <= word_d;
      buf_valid_q <= buf_valid_d;
      idx_q       <= idx_d;
      lim_q       <= lim_d;
    end
  end

endmodule

// File: rtl/ddr3_pix_gearbox.sv
// DDR3 pixel gearbox: packs PIX_W pixels into MEM_W words (packer, local) and
// unpacks MEM_W words back into pixels (ddr3_pix_unpack). Both halves run
// independently on ui_clk.
//   ui_clk : sole clock        rst_n : async active-low reset
//   bus    : all handshake/data signals, slave view
module ddr3_pix_gearbox
  import ddr3_gearbox_pkg::*;
#(
  parameter int unsigned PIX_W     = DefPixW,
  parameter int unsigned MEM_W     = DefMemW,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic               ui_clk,
  input logic               rst_n,
  ddr3_pix_gearbox_if.slave bus
);

  localparam int unsigned RATIO = MEM_W / PIX_W;
  localparam int unsigned CW    = clog2(RATIO) + 1;

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || RATIO * PIX_W != MEM_W) begin : gen_bad_ratio
    $error("ddr3_pix_gearbox: MEM_W/PIX_W must be a power of two of at least 2");
  end

  // Packer state
  logic [MEM_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    slot_q, slot_d;
  logic             out_valid_q, out_valid_d;
  logic [MEM_W-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_cnt_q, out_cnt_d;

  logic [MEM_W-1:0] acc_base, acc_fill;
  logic [CW-1:0]    slot_base;
  logic             pix_acc, word_done;

  assign bus.pix_in_ready  = ~out_valid_q | bus.mem_out_ready;
  assign pix_acc           = bus.pix_in_valid & bus.pix_in_ready;
  assign bus.mem_out_valid = out_valid_q;
  assign bus.mem_out_data  = out_data_q;
  assign bus.mem_out_cnt   = out_cnt_q;

  always_comb begin
    // wr_load drops the partial word first, so a same-cycle pixel lands in slot 0.
    acc_base  = bus.wr_load ? '0 : acc_q;
    slot_base = bus.wr_load ? '0 : slot_q;
    acc_fill  = acc_base |
                (MEM_W'(bus.pix_in_data) << slot_offset(32'(slot_base), RATIO, PIX_W, MSB_FIRST));
    word_done = pix_acc & (bus.pix_in_last | (slot_base == CW'(RATIO - 1)));

    acc_d       = acc_base;
    slot_d      = slot_base;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;

    if (bus.mem_out_ready) out_valid_d = 1'b0;
    // A pixel is only accepted when the output register is free or draining.
    if (word_done) begin
      acc_d       = '0;
      slot_d      = '0;
      out_valid_d = 1'b1;
      out_data_d  = acc_fill;
      out_cnt_d   = slot_base + 1'b1;
    end else if (pix_acc) begin
      acc_d  = acc_fill;
      slot_d = slot_base + 1'b1;
    end
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      slot_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      slot_q      <= slot_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  ddr3_pix_unpack #(
    .PIX_W     (PIX_W),
    .MEM_W     (MEM_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_unpack (
    .clk_i           (ui_clk),
    .rst_ni          (rst_n),
    .mem_in_valid_i  (bus.mem_in_valid),
    .mem_in_ready_o  (bus.mem_in_ready),
    .mem_in_data_i   (bus.mem_in_data),
    .mem_in_cnt_i    (bus.mem_in_cnt),
    .rd_load_i       (bus.rd_load),
    .pix_out_valid_o (bus.pix_out_valid),
    .pix_out_ready_i (bus.pix_out_ready),
    .pix_out_data_o  (bus.pix_out_data),
    .pix_out_last_o  (bus.pix_out_last)
  );

endmodule

// File: tb/tb_ddr3_pix_gearbox.sv
// Self-checking bench for ddr3_pix_gearbox: table-driven packer/unpacker
// vectors plus directed multi-cycle sequences (stall, wr_load, rd_load, reset).
module tb_ddr3_pix_gearbox;

  localparam int unsigned PixW = 16;
  localparam int unsigned MemW = 256;
  localparam int unsigned Cw   = 5;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ddr3_pix_gearbox_if #(.PIX_W(PixW), .MEM_W(MemW)) bus0 ();
  ddr3_pix_gearbox_if #(.PIX_W(PixW), .MEM_W(MemW)) bus1 ();

  ddr3_pix_gearbox #(.PIX_W(PixW), .MEM_W(MemW), .MSB_FIRST(1'b1)) u_dut0 (
    .ui_clk (clk),
    .rst_n  (rst_n),
    .bus    (bus0)
  );

  ddr3_pix_gearbox #(.PIX_W(PixW), .MEM_W(MemW), .MSB_FIRST(1'b0)) u_dut1 (
    .ui_clk (clk),
    .rst_n  (rst_n),
    .bus    (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic pre_valid;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [MemW-1:0] data; logic [Cw-1:0] cnt; } word_t;
  typedef struct { logic [PixW-1:0] data; logic last; int cyc; } pix_t;
  typedef struct { int npix; logic [PixW-1:0] base; bit use_last; int exp_cnt; } pack_vec_t;
  typedef struct { logic [Cw-1:0] cnt_in; logic [PixW-1:0] seed; int exp_n; } unpack_vec_t;

  word_t out_words[$];
  pix_t  out_pix[$];

  // Handshakes are stable at negedge and complete on the following posedge.
  always @(negedge clk) begin
    if (bus0.mem_out_valid && bus0.mem_out_ready)
      out_words.push_back('{bus0.mem_out_data, bus0.mem_out_cnt});
    if (bus0.pix_out_valid && bus0.pix_out_ready)
      out_pix.push_back('{bus0.pix_out_data, bus0.pix_out_last, cyc});
  end

  task automatic check(input string name, input logic [MemW-1:0] act, input logic [MemW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Word with slot k (first in time = top slot) holding base+k for k < n.
  function automatic logic [MemW-1:0] msb_word(input logic [PixW-1:0] base, input int n);
    logic [MemW-1:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[MemW-1-PixW*k -: PixW] = base + PixW'(k);
    return w;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Starts and returns at posedge+1; holds the pixel until accepted.
  task automatic push_pix(input logic [PixW-1:0] d, input logic last, input logic load);
    int t;
    logic acc;
    t = 0;
    bus0.pix_in_valid = 1'b1;
    bus0.pix_in_data  = d;
    bus0.pix_in_last  = last;
    bus0.wr_load      = load;
    forever begin
      @(negedge clk);
      acc = bus0.pix_in_ready;
      pre_valid = bus0.mem_out_valid;
      @(posedge clk);
      #1;
      bus0.wr_load = 1'b0;
      if (acc) break;
      t++;
      if (t > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL push_pix_timeout: pix_in_ready stayed 0, expected 1");
        break;
      end
    end
    bus0.pix_in_valid = 1'b0;
    bus0.pix_in_last  = 1'b0;
  endtask

  task automatic push_word(input logic [MemW-1:0] d, input logic [Cw-1:0] c);
    int t;
    logic acc;
    t = 0;
    bus0.mem_in_valid = 1'b1;
    bus0.mem_in_data  = d;
    bus0.mem_in_cnt   = c;
    forever begin
      @(negedge clk);
      acc = bus0.mem_in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL push_word_timeout: mem_in_ready stayed 0, expected 1");
        break;
      end
    end
    bus0.mem_in_valid = 1'b0;
  endtask

  pack_vec_t   pvec[4];
  unpack_vec_t uvec[6];
  word_t       w;
  pix_t        p;
  logic [MemW-1:0] lw;
  int c0, gaps, leak;

  initial begin
    pvec[0] = '{16, 16'h0001, 1'b0, 16};
    pvec[1] = '{3,  16'h00A0, 1'b1, 3};
    pvec[2] = '{1,  16'h00E0, 1'b1, 1};
    pvec[3] = '{8,  16'h0200, 1'b1, 8};
    uvec[0] = '{5'd16, 16'h1000, 16};
    uvec[1] = '{5'd4,  16'h2000, 4};
    uvec[2] = '{5'd0,  16'h3000, 16};
    uvec[3] = '{5'd17, 16'h4000, 16};
    uvec[4] = '{5'd1,  16'h5000, 1};
    uvec[5] = '{5'd31, 16'h6000, 16};

    rst_n = 1'b0;
    pre_valid = 1'b0;
    bus0.pix_in_valid = 0; bus0.pix_in_data = '0; bus0.pix_in_last = 0; bus0.wr_load = 0;
    bus0.mem_out_ready = 1; bus0.mem_in_valid = 0; bus0.mem_in_data = '0; bus0.mem_in_cnt = '0;
    bus0.rd_load = 0; bus0.pix_out_ready = 1;
    bus1.pix_in_valid = 0; bus1.pix_in_data = '0; bus1.pix_in_last = 0; bus1.wr_load = 0;
    bus1.mem_out_ready = 1; bus1.mem_in_valid = 0; bus1.mem_in_data = '0; bus1.mem_in_cnt = '0;
    bus1.rd_load = 0; bus1.pix_out_ready = 1;

    // Reset values
    #12;
    check("rst_mem_out_valid", MemW'(bus0.mem_out_valid), '0);
    check("rst_mem_out_data", bus0.mem_out_data, '0);
    check("rst_mem_out_cnt", MemW'(bus0.mem_out_cnt), '0);
    check("rst_pix_out_valid", MemW'(bus0.pix_out_valid), '0);
    check("rst_pix_out_last", MemW'(bus0.pix_out_last), '0);
    check("rst_pix_out_data", MemW'(bus0.pix_out_data), '0);
    check("rst_dut1_mem_out_valid", MemW'(bus1.mem_out_valid), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_cycles(2);

    // Packer table
    for (int r = 0; r < 4; r++) begin
      out_words.delete();
      c0 = cyc;
      for (int i = 0; i < pvec[r].npix; i++)
        push_pix(pvec[r].base + PixW'(i), pvec[r].use_last && (i == pvec[r].npix - 1), 1'b0);
      check($sformatf("pack%0d_cycles", r), MemW'(cyc - c0), MemW'(pvec[r].npix));
      check($sformatf("pack%0d_valid_before", r), MemW'(pre_valid), '0);
      @(negedge clk);
      check($sformatf("pack%0d_valid_after", r), MemW'(bus0.mem_out_valid), MemW'(1));
      wait_cycles(3);
      check($sformatf("pack%0d_nwords", r), MemW'(out_words.size()), MemW'(1));
      w = '{default: '0};
      if (out_words.size() > 0) w = out_words.pop_front();
      check($sformatf("pack%0d_data", r), w.data, msb_word(pvec[r].base, pvec[r].npix));
      check($sformatf("pack%0d_cnt", r), MemW'(w.cnt), MemW'(pvec[r].exp_cnt));
    end

    // Sink stalls 5 cycles after word 1 while 20 pixels are offered
    bus0.mem_out_ready = 1'b0;
    out_words.delete();
    fork
      begin
        for (int i = 0; i < 20; i++) push_pix(16'h0100 + PixW'(i), i == 19, 1'b0);
      end
      begin
        int t;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!bus0.mem_out_valid && t < 100);
        check("stall_word1_valid", MemW'(bus0.mem_out_valid), MemW'(1));
        check("stall_ready_low", MemW'(bus0.pix_in_ready), '0);
        leak = 0;
        repeat (4) begin
          @(negedge clk);
          if (bus0.pix_in_ready) leak++;
        end
        check("stall_ready_held_low", MemW'(leak), '0);
        @(posedge clk); #1;
        bus0.mem_out_ready = 1'b1;
      end
    join
    wait_cycles(5);
    check("stall_nwords", MemW'(out_words.size()), MemW'(2));
    w = '{default: '0};
    if (out_words.size() > 0) w = out_words.pop_front();
    check("stall_word1_data", w.data, msb_word(16'h0100, 16));
    check("stall_word1_cnt", MemW'(w.cnt), MemW'(16));
    w = '{default: '0};
    if (out_words.size() > 0) w = out_words.pop_front();
    check("stall_word2_data", w.data, msb_word(16'h0110, 4));
    check("stall_word2_cnt", MemW'(w.cnt), MemW'(4));

    // wr_load together with pixel 0x55 after 5 pixels
    out_words.delete();
    for (int i = 0; i < 5; i++) push_pix(16'h0011 + PixW'(i), 1'b0, 1'b0);
    push_pix(16'h0055, 1'b1, 1'b1);
    wait_cycles(3);
    check("wrload_nwords", MemW'(out_words.size()), MemW'(1));
    w = '{default: '0};
    if (out_words.size() > 0) w = out_words.pop_front();
    check("wrload_data", w.data, msb_word(16'h0055, 1));
    check("wrload_cnt", MemW'(w.cnt), MemW'(1));

    // Unpacker table
    for (int r = 0; r < 6; r++) begin
      out_pix.delete();
      push_word(msb_word(uvec[r].seed, 16), uvec[r].cnt_in);
      wait_cycles(20);
      check($sformatf("unpack%0d_npix", r), MemW'(out_pix.size()), MemW'(uvec[r].exp_n));
      for (int k = 0; k < uvec[r].exp_n; k++) begin
        p = '{default: '0};
        if (k < out_pix.size()) p = out_pix[k];
        check($sformatf("unpack%0d_pix%0d", r, k), MemW'(p.data), MemW'(uvec[r].seed + PixW'(k)));
        check($sformatf("unpack%0d_last%0d", r, k), MemW'(p.last),
              MemW'(k == uvec[r].exp_n - 1));
      end
    end

    // Back-to-back words, cnt 16 then 4
    out_pix.delete();
    push_word(msb_word(16'hA000, 16), 5'd16);
    push_word(msb_word(16'hB000, 16), 5'd4);
    wait_cycles(25);
    check("b2b_npix", MemW'(out_pix.size()), MemW'(20));
    gaps = 0;
    for (int k = 0; k < 20; k++) begin
      p = '{default: '0};
      if (k < out_pix.size()) p = out_pix[k];
      check($sformatf("b2b_pix%0d", k), MemW'(p.data),
            MemW'((k < 16) ? 16'hA000 + PixW'(k) : 16'hB000 + PixW'(k - 16)));
      check($sformatf("b2b_last%0d", k), MemW'(p.last), MemW'(k == 15 || k == 19));
      if (k > 0 && k < out_pix.size() && out_pix[k].cyc != out_pix[k-1].cyc + 1) gaps++;
    end
    check("b2b_gaps", MemW'(gaps), '0);

    // rd_load after 7 of 16 pixels
    out_pix.delete();
    push_word(msb_word(16'hC000, 16), 5'd16);
    wait_cycles(7);
    bus0.pix_out_ready = 1'b0;
    bus0.rd_load       = 1'b1;
    bus0.mem_in_valid  = 1'b1;
    bus0.mem_in_data   = msb_word(16'hD000, 16);
    bus0.mem_in_cnt    = 5'd2;
    @(negedge clk);
    check("rdload_in_ready_low", MemW'(bus0.mem_in_ready), '0);
    @(posedge clk); #1;
    bus0.rd_load       = 1'b0;
    bus0.pix_out_ready = 1'b1;
    @(negedge clk);
    check("rdload_valid_low", MemW'(bus0.pix_out_valid), '0);
    @(posedge clk); #1;
    bus0.mem_in_valid = 1'b0;
    @(negedge clk);
    check("rdload_new_valid", MemW'(bus0.pix_out_valid), MemW'(1));
    check("rdload_new_slot0", MemW'(bus0.pix_out_data), MemW'(16'hD000));
    wait_cycles(4);
    check("rdload_npix", MemW'(out_pix.size()), MemW'(9));
    for (int k = 0; k < 9; k++) begin
      p = '{default: '0};
      if (k < out_pix.size()) p = out_pix[k];
      check($sformatf("rdload_pix%0d", k), MemW'(p.data),
            MemW'((k < 7) ? 16'hC000 + PixW'(k) : 16'hD000 + PixW'(k - 7)));
    end

    // LSB-first instance: 3 pixels with last on the third
    bus1.pix_in_valid = 1'b1; bus1.pix_in_data = 16'h000A;
    @(posedge clk); #1; bus1.pix_in_data = 16'h000B;
    @(posedge clk); #1; bus1.pix_in_data = 16'h000C; bus1.pix_in_last = 1'b1;
    @(posedge clk); #1; bus1.pix_in_valid = 1'b0; bus1.pix_in_last = 1'b0;
    @(negedge clk);
    check("lsb_valid", MemW'(bus1.mem_out_valid), MemW'(1));
    check("lsb_data", bus1.mem_out_data, MemW'(64'h0000_000C_000B_000A));
    check("lsb_cnt", MemW'(bus1.mem_out_cnt), MemW'(3));
    lw = '0;
    lw[15:0]  = 16'h1111;
    lw[31:16] = 16'h2222;
    @(posedge clk); #1;
    bus1.mem_in_valid = 1'b1; bus1.mem_in_data = lw; bus1.mem_in_cnt = 5'd2;
    @(posedge clk); #1;
    bus1.mem_in_valid = 1'b0;
    @(negedge clk);
    check("lsb_unpack_pix0", MemW'(bus1.pix_out_data), MemW'(16'h1111));
    check("lsb_unpack_last0", MemW'(bus1.pix_out_last), '0);
    @(negedge clk);
    check("lsb_unpack_pix1", MemW'(bus1.pix_out_data), MemW'(16'h2222));
    check("lsb_unpack_last1", MemW'(bus1.pix_out_last), MemW'(1));
    wait_cycles(2);

    // Reset mid-word discards partial and buffered data
    for (int i = 0; i < 3; i++) push_pix(16'h0F00 + PixW'(i), 1'b0, 1'b0);
    bus0.pix_out_ready = 1'b0;
    push_word(msb_word(16'hE000, 16), 5'd16);
    out_words.delete();
    out_pix.delete();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pix_out_valid", MemW'(bus0.pix_out_valid), '0);
    check("midrst_pix_out_data", MemW'(bus0.pix_out_data), '0);
    check("midrst_mem_out_data", bus0.mem_out_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_mem_out_valid", MemW'(bus0.mem_out_valid), '0);
    check("postrst_pix_out_valid", MemW'(bus0.pix_out_valid), '0);
    @(posedge clk); #1;
    bus0.pix_out_ready = 1'b1;
    push_pix(16'h0077, 1'b1, 1'b0);
    wait_cycles(3);
    check("postrst_nwords", MemW'(out_words.size()), MemW'(1));
    w = '{default: '0};
    if (out_words.size() > 0) w = out_words.pop_front();
    check("postrst_data", w.data, msb_word(16'h0077, 1));
    check("postrst_cnt", MemW'(w.cnt), MemW'(1));
    check("postrst_no_stale_pix", MemW'(out_pix.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
